// File: rtl/fpadd_arb_pkg.sv
// Shared types and constants for the fpadd arbiter.
package fpadd_arb_pkg;

  localparam int unsigned DEF_NUM_REQ     = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 64;
  localparam int unsigned FP_W            = 32;

  // Quiet NaN returned when the shared adder never completes.
  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } arb_state_t;

endpackage

// File: rtl/fpadd_arbiter_rr_arbiter.sv
// Round-robin grant: lowest requesting index above last_idx, wrapping.
module rr_arbiter
  import fpadd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [31:0] cand;
  logic        found;

  // Scan the NUM_REQ positions after last_idx; first requester found wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = 32'(last_idx) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                    = 1'b1;
        grant[cand[IDX_W-1:0]]   = 1'b1;
        grant_idx                = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fpadd_arbiter.sv
// Shares one multi-cycle fpadd unit among NUM_REQ requesters.
// Optional watchdog: define FPADD_ARB_TIMEOUT_EN to abort a WAIT that
// lasts TIMEOUT_CYC cycles with rsp_err=1 and a quiet-NaN result.
module fpadd_arbiter
  import fpadd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [FP_W*NUM_REQ-1:0] req_a,
  input  logic [FP_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [FP_W-1:0]         rsp_sum,
  output logic                    rsp_err,
  output logic                    fpu_start,
  output logic [FP_W-1:0]         fpu_a,
  output logic [FP_W-1:0]         fpu_b,
  input  logic [FP_W-1:0]         fpu_sum,
  input  logic                    fpu_done
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  // Reject unsupported configurations at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("fpadd_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  arb_state_t          state;
  logic [IDX_W-1:0]    last_grant;
  logic [NUM_REQ-1:0]  owner_oh;
  logic [FP_W-1:0]     op_a;
  logic [FP_W-1:0]     op_b;
  logic [FP_W-1:0]     result;

  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    grant_idx;
  logic [FP_W-1:0]     a_sel;
  logic [FP_W-1:0]     b_sel;

`ifdef FPADD_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .last_idx  (last_grant),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Select the granted requester's operand pair.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*FP_W +: FP_W];
        b_sel = req_b[i*FP_W +: FP_W];
      end
    end
  end

  assign rsp_sum = result;
  assign fpu_a   = op_a;
  assign fpu_b   = op_b;

  // Operation sequencer: grant, issue, wait, respond, drain stale done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      owner_oh   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      result     <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      fpu_start  <= 1'b0;
`ifdef FPADD_ARB_TIMEOUT_EN
      wait_cnt   <= '0;
      rsp_err    <= 1'b0;
`endif
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            req_ready  <= grant;
            owner_oh   <= grant;
            last_grant <= grant_idx;
            op_a       <= a_sel;
            op_b       <= b_sel;
            fpu_start  <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
`ifdef FPADD_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (fpu_done) begin
            result    <= fpu_sum;
            fpu_start <= 1'b0;
            rsp_valid <= owner_oh;
            state     <= ST_RESP;
`ifdef FPADD_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            result    <= QNAN;
            rsp_err   <= 1'b1;
            fpu_start <= 1'b0;
            rsp_valid <= owner_oh;
            state     <= ST_RESP;
          end else begin
            wait_cnt  <= wait_cnt + CNT_W'(1);
`endif
          end
        end
        ST_RESP: begin
          state <= ST_DRAIN;
`ifdef FPADD_ARB_TIMEOUT_EN
          rsp_err <= 1'b0;
`endif
        end
        ST_DRAIN: begin
          if (!fpu_done) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          fpu_start <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
